// File: rtl/addsub_nibble_serial_ctrl_pkg.sv
// Shared types for the nibble-serial add/subtract sequencer.
//   state_t      : controller FSM states
//   NIBBLE_W     : width of the external adder-subtractor slice
//   slice_drive(): maps (effective B nibble, running carry) onto the slice's
//                  b/cin inputs so that the slice computes a + nib_b + c.
package addsub_nibble_serial_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] b;
    logic                cin;
  } slice_drv_t;

  // In subtract mode the slice adds ~b + 1. With cin = c, pre-inverting b
  // when c=1 turns that back into a + nib_b + 1, so the running carry can be
  // chained through the slice's mode input.
  function automatic slice_drv_t slice_drive(input logic [NIBBLE_W-1:0] nib_b,
                                             input logic                c);
    slice_drv_t d;
    d.b   = c ? ~nib_b : nib_b;
    d.cin = c;
    return d;
  endfunction

endpackage

// File: rtl/addsub_result_flags.sv
// Combinational result flags for an add/subtract stage.
//   sum   : W-bit result (modulo 2^W)
//   c     : final carry-out (for subtract, 1 = no borrow)
//   a_msb : sign bit of operand A
//   b_msb : sign bit of the effective B operand (inverted B for subtract)
//   carry/ovf/zero : carry, signed overflow, result-is-zero
module addsub_result_flags #(
  parameter int W = 16
) (
  input  logic [W-1:0] sum,
  input  logic         c,
  input  logic         a_msb,
  input  logic         b_msb,
  output logic         carry,
  output logic         ovf,
  output logic         zero
);

  assign carry = c;
  // Same-signed operands producing a differently-signed result.
  assign ovf   = (a_msb == b_msb) && (sum[W-1] != a_msb);
  assign zero  = (sum == '0);

endmodule

// File: rtl/addsub_nibble_serial_ctrl.sv
// W-bit add/subtract (W = 4*NIBBLES) using one external 4-bit slice,
// one nibble per cycle, LSB nibble first.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/ready, req_a/b/sub : operand request handshake
//   slice_a/b/cin, slice_s/c0  : external slice drive and result
//   rsp_valid/ready, rsp_sum/carry/ovf/zero : result handshake and flags
module addsub_nibble_serial_ctrl
  import addsub_nibble_serial_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [W-1:0]        req_a,
  input  logic [W-1:0]        req_b,
  input  logic                req_sub,
  output logic [NIBBLE_W-1:0] slice_a,
  output logic [NIBBLE_W-1:0] slice_b,
  output logic                slice_cin,
  input  logic [NIBBLE_W-1:0] slice_s,
  input  logic                slice_c0,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_carry,
  output logic                rsp_ovf,
  output logic                rsp_zero
);

  localparam int             IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NIBBLES - 1);

  state_t        state;
  logic [W-1:0]  a_q, beff_q;
  logic [IW-1:0] idx, nxt_idx;
  logic [W-1:0]  beff_in, sum_nxt;
  slice_drv_t    drv_first, drv_next;
  logic          f_carry, f_ovf, f_zero;

  function automatic logic [NIBBLE_W-1:0] nib(input logic [W-1:0]  v,
                                              input logic [IW-1:0] i);
    return v[int'(i)*NIBBLE_W +: NIBBLE_W];
  endfunction

  assign nxt_idx   = idx + 1'b1;
  assign beff_in   = req_sub ? ~req_b : req_b;
  assign drv_first = slice_drive(beff_in[NIBBLE_W-1:0], req_sub);
  // Slice outputs are registered, so the next nibble's drive is built from
  // the carry the slice is producing right now.
  assign drv_next  = slice_drive(nib(beff_q, nxt_idx), slice_c0);

  always_comb begin
    sum_nxt = rsp_sum;
    sum_nxt[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_s;
  end

  // Flags are evaluated on the sum including the nibble being written on the
  // final RUN edge, then registered into DONE.
  addsub_result_flags #(.W(W)) u_flags (
    .sum   (sum_nxt),
    .c     (slice_c0),
    .a_msb (a_q[W-1]),
    .b_msb (beff_q[W-1]),
    .carry (f_carry),
    .ovf   (f_ovf),
    .zero  (f_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_zero  <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      beff_q    <= '0;
      slice_a   <= '0;
      slice_b   <= '0;
      slice_cin <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q       <= req_a;
          beff_q    <= beff_in;
          idx       <= '0;
          req_ready <= 1'b0;
          slice_a   <= req_a[NIBBLE_W-1:0];
          slice_b   <= drv_first.b;
          slice_cin <= drv_first.cin;
          state     <= RUN;
        end
        RUN: begin
          rsp_sum <= sum_nxt;
          if (idx == LAST) begin
            rsp_valid <= 1'b1;
            rsp_carry <= f_carry;
            rsp_ovf   <= f_ovf;
            rsp_zero  <= f_zero;
            slice_a   <= '0;
            slice_b   <= '0;
            slice_cin <= 1'b0;
            state     <= DONE;
          end else begin
            idx       <= nxt_idx;
            slice_a   <= nib(a_q, nxt_idx);
            slice_b   <= drv_next.b;
            slice_cin <= drv_next.cin;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_nibble_serial_ctrl.sv
module tb_addsub_nibble_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        rst;
  // 4-nibble instance
  logic        req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b, rsp_sum;
  logic        rsp_carry, rsp_ovf, rsp_zero;
  logic [3:0]  slice_a, slice_b, slice_s;
  logic        slice_cin, slice_c0;
  logic [4:0]  s5;
  // 1-nibble instance
  logic        req_valid1, req_ready1, req_sub1, rsp_valid1, rsp_ready1;
  logic [3:0]  req_a1, req_b1, rsp_sum1;
  logic        rsp_carry1, rsp_ovf1, rsp_zero1;
  logic [3:0]  slice_a1, slice_b1, slice_s1;
  logic        slice_cin1, slice_c01;
  logic [4:0]  s51;

  addsub_nibble_serial_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_s(slice_s), .slice_c0(slice_c0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero)
  );

  addsub_nibble_serial_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_sub(req_sub1),
    .slice_a(slice_a1), .slice_b(slice_b1), .slice_cin(slice_cin1),
    .slice_s(slice_s1), .slice_c0(slice_c01),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_sum(rsp_sum1), .rsp_carry(rsp_carry1), .rsp_ovf(rsp_ovf1), .rsp_zero(rsp_zero1)
  );

  // Behavioural slices: cin=0 -> a+b, cin=1 -> a+~b+1.
  always_comb begin
    s5       = {1'b0, slice_a} + {1'b0, (slice_cin ? ~slice_b : slice_b)} + 5'(slice_cin);
    slice_s  = s5[3:0];
    slice_c0 = s5[4];
  end
  always_comb begin
    s51       = {1'b0, slice_a1} + {1'b0, (slice_cin1 ? ~slice_b1 : slice_b1)} + 5'(slice_cin1);
    slice_s1  = s51[3:0];
    slice_c01 = s51[4];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden W-bit model: {zero, ovf, carry, sum}
  function automatic logic [18:0] gold(input int w, input logic [15:0] a, b, input logic sub);
    logic [31:0] aa, bb, t, m, s;
    logic c, o, sa, sb, ss;
    m  = (32'd1 << w) - 32'd1;
    aa = 32'(a) & m;
    bb = 32'(b) & m;
    t  = sub ? aa - bb : aa + bb;
    s  = t & m;
    c  = sub ? (aa >= bb) : t[w];
    sa = aa[w-1]; sb = bb[w-1]; ss = s[w-1];
    o  = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    return {(s == 0), o, c, s[15:0]};
  endfunction

  task automatic start_req(input logic [15:0] a, b, input logic sub);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the negedge of the first RUN cycle; returns slice_cin history.
  task automatic wait_done(output logic [3:0] seq);
    int cyc = 0;
    seq = '0;
    while (!rsp_valid && cyc < 20) begin
      seq = {seq[2:0], slice_cin};
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] s,
                         input logic c, input logic o, input logic z);
    chk({tag, "_sum"},   rsp_sum,   s);
    chk({tag, "_carry"}, rsp_carry, c);
    chk({tag, "_ovf"},   rsp_ovf,   o);
    chk({tag, "_zero"},  rsp_zero,  z);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [15:0] va[3], vb[3];
  logic        vs[3];
  logic [3:0]  seq;
  logic [18:0] g;

  initial begin
    rst = 1'b1;
    req_valid = 0; req_a = 0; req_b = 0; req_sub = 0; rsp_ready = 0;
    req_valid1 = 0; req_a1 = 0; req_b1 = 0; req_sub1 = 0; rsp_ready1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outputs", {rsp_sum, rsp_carry, rsp_ovf, rsp_zero}, '0);
    chk("rst_slice", {slice_a, slice_b, slice_cin}, '0);

    // add with carry ripple through the middle nibbles
    start_req(16'h1234, 16'h0FFF, 1'b0);
    wait_done(seq);
    chk("add_cin_seq", seq, 4'b0111);
    chk_rsp("add", 16'h2233, 0, 0, 0);
    ack();

    // subtract with borrow
    start_req(16'h0005, 16'h0007, 1'b1);
    wait_done(seq);
    chk_rsp("sub_borrow", 16'hFFFE, 0, 0, 0);
    ack();

    // positive overflow
    start_req(16'h7FFF, 16'h0001, 1'b0);
    wait_done(seq);
    chk_rsp("ovf_pos", 16'h8000, 0, 1, 0);
    ack();

    // negative overflow wrapping to zero
    start_req(16'h8000, 16'h8000, 1'b0);
    wait_done(seq);
    chk_rsp("ovf_neg", 16'h0000, 1, 1, 1);
    ack();

    // equal operands subtract, held response with a waiting request
    start_req(16'hA5A5, 16'hA5A5, 1'b1);
    wait_done(seq);
    chk_rsp("sub_eq", 16'h0000, 1, 0, 1);
    req_a = 16'h1234; req_b = 16'h0001; req_sub = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_out", {rsp_sum, rsp_carry, rsp_ovf, rsp_zero}, {16'h0000, 3'b101});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", rsp_valid, 1'b0);
    chk("hs_req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("accept_after_hs", req_ready, 1'b0);
    wait_done(seq);
    chk_rsp("queued", 16'h1235, 0, 0, 0);
    ack();

    // reset in the 2nd RUN cycle
    start_req(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_slice", {slice_a, slice_b, slice_cin}, '0);
    begin
      int bad = 0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid) bad++;
      end
      chk("abort_no_rsp", bad, 0);
    end
    start_req(16'hFFFF, 16'h0001, 1'b0);
    wait_done(seq);
    chk_rsp("after_abort", 16'h0000, 1, 0, 1);
    ack();

    // back-to-back, 4 nibbles
    va[0] = 16'h1234; vb[0] = 16'h0FFF; vs[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1;
    va[2] = 16'h0003; vb[2] = 16'h0003; vs[2] = 1'b1;
    begin
      int issued = 0, got = 0, last_t = 0;
      rsp_ready = 1'b1;
      for (int t = 0; t < 60 && got < 3; t++) begin
        @(negedge clk);
        if (rsp_valid) begin
          g = gold(16, va[got], vb[got], vs[got]);
          chk("b2b_sum", rsp_sum, g[15:0]);
          chk("b2b_flags", {rsp_zero, rsp_ovf, rsp_carry}, g[18:16]);
          if (got > 0) chk("b2b_period", t - last_t, 6);
          last_t = t;
          got++;
        end
        if (req_ready) begin
          if (issued < 3) begin
            req_a = va[issued]; req_b = vb[issued]; req_sub = vs[issued];
            req_valid = 1'b1;
            issued++;
          end else req_valid = 1'b0;
        end
      end
      if (got < 3) chk("b2b_timeout", got, 3);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
    end

    // back-to-back, 1 nibble
    va[0] = 16'h7; vb[0] = 16'h1; vs[0] = 1'b0;
    va[1] = 16'h3; vb[1] = 16'h5; vs[1] = 1'b1;
    va[2] = 16'hF; vb[2] = 16'h1; vs[2] = 1'b0;
    begin
      int issued = 0, got = 0, last_t = 0;
      rsp_ready1 = 1'b1;
      for (int t = 0; t < 40 && got < 3; t++) begin
        @(negedge clk);
        if (rsp_valid1) begin
          g = gold(4, va[got], vb[got], vs[got]);
          chk("n1_sum", rsp_sum1, g[3:0]);
          chk("n1_flags", {rsp_zero1, rsp_ovf1, rsp_carry1}, g[18:16]);
          if (got > 0) chk("n1_period", t - last_t, 3);
          last_t = t;
          got++;
        end
        if (req_ready1) begin
          if (issued < 3) begin
            req_a1 = va[issued][3:0]; req_b1 = vb[issued][3:0]; req_sub1 = vs[issued];
            req_valid1 = 1'b1;
            issued++;
          end else req_valid1 = 1'b0;
        end
      end
      if (got < 3) chk("n1_timeout", got, 3);
      req_valid1 = 1'b0;
      rsp_ready1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
